// File: rtl/pirdsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// PirdspMacPipe : three-stage multiply/accumulate pipeline with SIMD dot mode
//
// Purpose
//    One full-width WIDTH x WIDTH multiply on channel 0, or GROUPS parallel
//    dot products, each summing LPG = WIDTH/SUB lane products. Either result
//    can feed a wrapping accumulator. Beats move through the stages
//    S1 (input register), S2 (products) and S3 (sum/accumulate/output).
//    The pipeline advances only when the output register is empty or
//    being consumed.
//
// Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    in_valid / in_ready   input beat handshake (in_ready is combinational)
//    a, b                  GROUPS*WIDTH operands, channel g at [g*WIDTH +: WIDTH]
//    a_sign, b_sign        1 = two's complement operands (per lane in SIMD)
//    mode                  00 FULL, 01 DOT, 10 FULL_ACC, 11 DOT_ACC
//    acc_clr               beat restarts its accumulator from zero
//    out_valid / out_ready output handshake
//    result_full           FULL_W-bit product or accumulator
//    result_dot            packed per-channel dot results, DOT_W bits each
// ---------------------------------------------------------------------------
module pirdsp_mac_pipe #(
   parameter int WIDTH    = 27,
   parameter int SUB      = 9,
   parameter int GROUPS   = 3,
   parameter int ACC_BITS = 8,
   localparam int LPG     = WIDTH / SUB,
   localparam int FULL_W  = 2*WIDTH + ACC_BITS,
   localparam int DOT_W   = 2*SUB + $clog2(LPG) + 1 + ACC_BITS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [GROUPS*WIDTH-1:0]   a,
   input  logic [GROUPS*WIDTH-1:0]   b,
   input  logic                      a_sign,
   input  logic                      b_sign,
   input  logic [1:0]                mode,
   input  logic                      acc_clr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [FULL_W-1:0]         result_full,
   output logic [GROUPS*DOT_W-1:0]   result_dot
);

   localparam int LANES = GROUPS * LPG;

   typedef enum logic [1:0] {
      MODE_FULL     = 2'b00,
      MODE_DOT      = 2'b01,
      MODE_FULL_ACC = 2'b10,
      MODE_DOT_ACC  = 2'b11
   } mode_e;

   logic                    advance;

   logic                    s1_valid_q;
   mode_e                   s1_mode_q;
   logic                    s1_a_sign_q;
   logic                    s1_b_sign_q;
   logic                    s1_clr_q;
   logic [GROUPS*WIDTH-1:0] s1_a_q;
   logic [GROUPS*WIDTH-1:0] s1_b_q;

   logic                    s2_valid_q;
   mode_e                   s2_mode_q;
   logic                    s2_clr_q;
   logic [FULL_W-1:0]       s2_full_prod_q;
   logic [DOT_W-1:0]        s2_lane_prod_q [LANES];

   logic                    out_valid_q;
   logic [FULL_W-1:0]       result_full_q;
   logic [GROUPS*DOT_W-1:0] result_dot_q;
   logic [FULL_W-1:0]       acc_full_q;
   logic [DOT_W-1:0]        acc_dot_q [GROUPS];

   logic [FULL_W-1:0]       full_a;
   logic [FULL_W-1:0]       full_b;
   logic [SUB-1:0]          lane_a;
   logic [SUB-1:0]          lane_b;
   logic [DOT_W-1:0]        lane_a_ext;
   logic [DOT_W-1:0]        lane_b_ext;
   logic [FULL_W-1:0]       full_prod_d;
   logic [DOT_W-1:0]        lane_prod_d [LANES];

   logic [DOT_W-1:0]        dot_sum [GROUPS];
   logic [FULL_W-1:0]       acc_full_d;
   logic [DOT_W-1:0]        acc_dot_d [GROUPS];
   logic [FULL_W-1:0]       result_full_d;
   logic [GROUPS*DOT_W-1:0] result_dot_d;

   // The whole pipeline moves as one: a full output register that is not
   // being taken freezes every stage, so in_ready is that same condition.
   assign advance     = !out_valid_q || out_ready;
   assign in_ready    = advance;
   assign out_valid   = out_valid_q;
   assign result_full = result_full_q;
   assign result_dot  = result_dot_q;

   // S2 product generation. Operands are sign- or zero-extended into the
   // result width first, so a plain unsigned multiply truncated to that
   // width yields the correct two's complement product for every sign mix.
   // Lane k of channel g sits at bit (g*LPG+k)*SUB because WIDTH = LPG*SUB.
   always_comb begin
      full_a      = {{(FULL_W-WIDTH){s1_a_sign_q & s1_a_q[WIDTH-1]}}, s1_a_q[WIDTH-1:0]};
      full_b      = {{(FULL_W-WIDTH){s1_b_sign_q & s1_b_q[WIDTH-1]}}, s1_b_q[WIDTH-1:0]};
      full_prod_d = full_a * full_b;
      lane_a      = '0;
      lane_b      = '0;
      lane_a_ext  = '0;
      lane_b_ext  = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_a         = s1_a_q[i*SUB +: SUB];
         lane_b         = s1_b_q[i*SUB +: SUB];
         lane_a_ext     = {{(DOT_W-SUB){s1_a_sign_q & lane_a[SUB-1]}}, lane_a};
         lane_b_ext     = {{(DOT_W-SUB){s1_b_sign_q & lane_b[SUB-1]}}, lane_b};
         lane_prod_d[i] = lane_a_ext * lane_b_ext;
      end
   end

   // S3 lane summation, accumulator next values and output selection.
   // The accumulators only take these values on an ACC beat of the matching
   // kind; everything wraps naturally at the register width.
   always_comb begin
      for (int g = 0; g < GROUPS; g++) begin
         dot_sum[g] = '0;
         for (int k = 0; k < LPG; k++) begin
            dot_sum[g] = dot_sum[g] + s2_lane_prod_q[g*LPG + k];
         end
         acc_dot_d[g] = (s2_clr_q ? {DOT_W{1'b0}} : acc_dot_q[g]) + dot_sum[g];
      end
      acc_full_d    = (s2_clr_q ? {FULL_W{1'b0}} : acc_full_q) + s2_full_prod_q;
      result_full_d = '0;
      result_dot_d  = '0;
      case (s2_mode_q)
         MODE_FULL:     result_full_d = s2_full_prod_q;
         MODE_FULL_ACC: result_full_d = acc_full_d;
         MODE_DOT: begin
            for (int g = 0; g < GROUPS; g++) result_dot_d[g*DOT_W +: DOT_W] = dot_sum[g];
         end
         MODE_DOT_ACC: begin
            for (int g = 0; g < GROUPS; g++) result_dot_d[g*DOT_W +: DOT_W] = acc_dot_d[g];
         end
         default: ;
      endcase
   end

   // All stage registers and accumulators. Reset wipes everything so beats
   // in flight vanish. Bubbles (valid=0) shift through but never touch the
   // accumulators or the held result values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q     <= 1'b0;
         s1_mode_q      <= MODE_FULL;
         s1_a_sign_q    <= 1'b0;
         s1_b_sign_q    <= 1'b0;
         s1_clr_q       <= 1'b0;
         s1_a_q         <= '0;
         s1_b_q         <= '0;
         s2_valid_q     <= 1'b0;
         s2_mode_q      <= MODE_FULL;
         s2_clr_q       <= 1'b0;
         s2_full_prod_q <= '0;
         for (int i = 0; i < LANES; i++) s2_lane_prod_q[i] <= '0;
         out_valid_q    <= 1'b0;
         result_full_q  <= '0;
         result_dot_q   <= '0;
         acc_full_q     <= '0;
         for (int g = 0; g < GROUPS; g++) acc_dot_q[g] <= '0;
      end else if (advance) begin
         s1_valid_q     <= in_valid;
         s1_mode_q      <= mode_e'(mode);
         s1_a_sign_q    <= a_sign;
         s1_b_sign_q    <= b_sign;
         s1_clr_q       <= acc_clr;
         s1_a_q         <= a;
         s1_b_q         <= b;
         s2_valid_q     <= s1_valid_q;
         s2_mode_q      <= s1_mode_q;
         s2_clr_q       <= s1_clr_q;
         s2_full_prod_q <= full_prod_d;
         for (int i = 0; i < LANES; i++) s2_lane_prod_q[i] <= lane_prod_d[i];
         out_valid_q    <= s2_valid_q;
         if (s2_valid_q) begin
            result_full_q <= result_full_d;
            result_dot_q  <= result_dot_d;
            if (s2_mode_q == MODE_FULL_ACC) acc_full_q <= acc_full_d;
            if (s2_mode_q == MODE_DOT_ACC) begin
               for (int g = 0; g < GROUPS; g++) acc_dot_q[g] <= acc_dot_d[g];
            end
         end
      end
   end

endmodule

// File: tb/tb_pirdsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_pirdsp_mac_pipe : directed self-checking bench for pirdsp_mac_pipe
//
// Drives inputs 1 time unit after the rising edge and samples outputs in the
// same window; a negedge monitor logs every accepted output into queues.
// Default parameters: WIDTH 27, SUB 9, GROUPS 3, ACC_BITS 8
// -> FULL_W 62, DOT_W 29.
// ---------------------------------------------------------------------------
module tb_pirdsp_mac_pipe;

   localparam int WIDTH  = 27;
   localparam int SUB    = 9;
   localparam int GROUPS = 3;
   localparam int FULL_W = 62;
   localparam int DOT_W  = 29;
   localparam int AW     = GROUPS * WIDTH;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [AW-1:0]           a = '0;
   logic [AW-1:0]           b = '0;
   logic                    a_sign = 1'b0;
   logic                    b_sign = 1'b0;
   logic [1:0]              mode = 2'b00;
   logic                    acc_clr = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [FULL_W-1:0]       result_full;
   logic [GROUPS*DOT_W-1:0] result_dot;

   int compared = 0;
   int mismatched = 0;

   logic [FULL_W-1:0]       qFull [$];
   logic [GROUPS*DOT_W-1:0] qDot [$];

   pirdsp_mac_pipe #(.WIDTH(WIDTH), .SUB(SUB), .GROUPS(GROUPS), .ACC_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .result_full(result_full), .result_dot(result_dot)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Output monitor: a result counts as delivered when it is valid and taken.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         qFull.push_back(result_full);
         qDot.push_back(result_dot);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] m, input logic sa, input logic sb,
                                input logic clr, input logic [AW-1:0] av, input logic [AW-1:0] bv);
      in_valid = v;
      mode     = m;
      a_sign   = sa;
      b_sign   = sb;
      acc_clr  = clr;
      a        = av;
      b        = bv;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // Reset values, and in_ready high even with out_ready low.
   task automatic test_reset();
      out_ready = 1'b0;
      tick();
      tick();
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      compared++;
      if (result_full !== '0) begin mismatched++; $display("[TB] FAIL reset_result_full: got %h expected 0", result_full); end
      compared++;
      if (result_dot !== '0) begin mismatched++; $display("[TB] FAIL reset_result_dot: got %h expected 0", result_dot); end
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
   endtask

   // Single FULL beats: exact 3-cycle latency, one-cycle valid, sign mixes.
   task automatic test_full();
      logic [AW-1:0]     ta [4];
      logic [AW-1:0]     tb [4];
      logic              tsa [4];
      logic              tsb [4];
      logic [FULL_W-1:0] te [4];
      ta[0] = AW'(27'h7FFFFFF); tb[0] = AW'(3);            tsa[0] = 1; tsb[0] = 1;
      te[0] = {FULL_W{1'b1}} - FULL_W'(2);
      ta[1] = AW'(27'h7FFFFFF); tb[1] = AW'(3);            tsa[1] = 0; tsb[1] = 0;
      te[1] = FULL_W'(402653181);
      ta[2] = AW'(27'h7FFFFFF); tb[2] = AW'(27'h7FFFFFF);  tsa[2] = 1; tsb[2] = 0;
      te[2] = {FULL_W{1'b1}} - FULL_W'(134217726);
      ta[3] = AW'(27'h4000000); tb[3] = AW'(27'h4000000);  tsa[3] = 1; tsb[3] = 1;
      te[3] = FULL_W'(1) << 52;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'b00, tsa[i], tsb[i], 1'b0, ta[i], tb[i]);
         tick();
         idle();
         tick();
         compared++;
         if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full%0d_early_valid: got %b expected 0", i, out_valid); end
         tick();
         compared++;
         if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL full%0d_valid: got %b expected 1", i, out_valid); end
         compared++;
         if (result_full !== te[i]) begin mismatched++; $display("[TB] FAIL full%0d_result: got %h expected %h", i, result_full, te[i]); end
         compared++;
         if (result_dot !== '0) begin mismatched++; $display("[TB] FAIL full%0d_dot_zero: got %h expected 0", i, result_dot); end
         tick();
         compared++;
         if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full%0d_single_valid: got %b expected 0", i, out_valid); end
      end
   endtask

   // DOT beats back to back: unsigned all-ones, then per-channel signed mix.
   task automatic test_dot();
      logic [GROUPS*DOT_W-1:0] exp0;
      logic [GROUPS*DOT_W-1:0] exp1;
      exp0 = {3{29'd783363}};
      exp1 = {29'd196608, 29'h1FFFFFFA, 29'd32};
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, {AW{1'b1}}, {AW{1'b1}});
      tick();
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0,
                    {9'h100, 9'h100, 9'h100, 9'h1FF, 9'h1FF, 9'h1FF, 9'd3, 9'd2, 9'd1},
                    {9'h100, 9'h100, 9'h100, 9'd2, 9'd2, 9'd2, 9'd6, 9'd5, 9'd4});
      tick();
      idle();
      tick();
      compared++;
      if (out_valid !== 1'b1 || result_dot !== exp0) begin mismatched++; $display("[TB] FAIL dot_unsigned: got v=%b %h expected v=1 %h", out_valid, result_dot, exp0); end
      compared++;
      if (result_full !== '0) begin mismatched++; $display("[TB] FAIL dot_full_zero: got %h expected 0", result_full); end
      tick();
      compared++;
      if (out_valid !== 1'b1 || result_dot !== exp1) begin mismatched++; $display("[TB] FAIL dot_signed: got v=%b %h expected v=1 %h", out_valid, result_dot, exp1); end
      tick();
   endtask

   // FULL_ACC chain 2*3, 4*5, 1*1 -> 6, 26, 27 on consecutive cycles.
   task automatic test_full_acc();
      logic [FULL_W-1:0] exp [3];
      exp[0] = FULL_W'(6);
      exp[1] = FULL_W'(26);
      exp[2] = FULL_W'(27);
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, AW'(2), AW'(3));
      tick();
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, AW'(4), AW'(5));
      tick();
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, AW'(1), AW'(1));
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         compared++;
         if (out_valid !== 1'b1 || result_full !== exp[i]) begin
            mismatched++;
            $display("[TB] FAIL full_acc%0d: got v=%b %0d expected v=1 %0d", i, out_valid, result_full, exp[i]);
         end
         tick();
      end
   endtask

   // Mode changes every beat; a FULL and a DOT beat sit between ACC beats.
   task automatic test_mixed_modes();
      logic [AW-1:0]           ones;
      logic [FULL_W-1:0]       expF [4];
      logic [GROUPS*DOT_W-1:0] expD [4];
      ones = {9{9'd1}};
      expF[0] = FULL_W'(9);  expD[0] = '0;
      expF[1] = FULL_W'(4);  expD[1] = '0;
      expF[2] = '0;          expD[2] = {3{29'd3}};
      expF[3] = FULL_W'(10); expD[3] = '0;
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, AW'(3), AW'(3));
      tick();
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, AW'(2), AW'(2));
      tick();
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, ones, ones);
      tick();
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, AW'(1), AW'(1));
      for (int i = 0; i < 4; i++) begin
         if (i == 1) idle();
         compared++;
         if (out_valid !== 1'b1 || result_full !== expF[i] || result_dot !== expD[i]) begin
            mismatched++;
            $display("[TB] FAIL mixed%0d: got v=%b f=%h d=%h expected v=1 f=%h d=%h",
                     i, out_valid, result_full, result_dot, expF[i], expD[i]);
         end
         tick();
      end
      idle();
   endtask

   // Ten-beat stream with out_ready low in cycles 4-7.
   task automatic test_back_to_back();
      int sent;
      sent = 0;
      qFull.delete();
      qDot.delete();
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 4 && c <= 7);
         if (sent < 10) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, AW'(sent + 1), AW'(sent + 2));
         else idle();
         #1;
         if (c >= 4 && c <= 7) begin
            compared++;
            if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_in_ready c%0d: got %b expected 0", c, in_ready); end
            compared++;
            if (out_valid !== 1'b1 || result_full !== FULL_W'(6)) begin
               mismatched++;
               $display("[TB] FAIL stall_hold c%0d: got v=%b %0d expected v=1 6", c, out_valid, result_full);
            end
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      idle();
      out_ready = 1'b1;
      compared++;
      if (qFull.size() != 10) begin mismatched++; $display("[TB] FAIL stream_count: got %0d expected 10", qFull.size()); end
      for (int i = 0; i < 10; i++) begin
         if (i < qFull.size()) begin
            compared++;
            if (qFull[i] !== FULL_W'((i + 1) * (i + 2))) begin
               mismatched++;
               $display("[TB] FAIL stream_order%0d: got %0d expected %0d", i, qFull[i], (i + 1) * (i + 2));
            end
         end
      end
   endtask

   // Signed DOT_ACC of (-256)*(-256) lanes until the field wraps negative.
   task automatic test_dot_acc_wrap();
      logic [AW-1:0]    m256;
      longint           step;
      logic [DOT_W-1:0] expBefore;
      logic [DOT_W-1:0] expAfter;
      m256 = {9{9'h100}};
      step = 3 * 256 * 256;
      expBefore = DOT_W'(1365 * step);
      expAfter  = DOT_W'(1366 * step);
      qDot.delete();
      qFull.delete();
      for (int i = 0; i < 1366; i++) begin
         applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, (i == 0), m256, m256);
         tick();
      end
      idle();
      repeat (4) tick();
      compared++;
      if (qDot.size() != 1366) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d expected 1366", qDot.size()); end
      if (qDot.size() == 1366) begin
         for (int g = 0; g < GROUPS; g++) begin
            compared++;
            if (qDot[1364][g*DOT_W +: DOT_W] !== expBefore) begin
               mismatched++;
               $display("[TB] FAIL wrap_before ch%0d: got %h expected %h", g, qDot[1364][g*DOT_W +: DOT_W], expBefore);
            end
            compared++;
            if (qDot[1365][g*DOT_W +: DOT_W] !== expAfter) begin
               mismatched++;
               $display("[TB] FAIL wrap_after ch%0d: got %h expected %h", g, qDot[1365][g*DOT_W +: DOT_W], expAfter);
            end
         end
         compared++;
         if (qDot[1365][DOT_W-1] !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_negative: got %b expected 1", qDot[1365][DOT_W-1]); end
      end
   endtask

   // Reset with beats in flight: everything cleared, nothing emerges later,
   // and the accumulators restart from zero without acc_clr.
   task automatic test_reset_midflight();
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, AW'(10), AW'(10));
      tick();
      idle();
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, AW'(2), AW'(2));
         tick();
      end
      idle();
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL midflight_pre_valid: got %b expected 1", out_valid); end
      rst_n = 1'b0;
      #1;
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midflight_out_valid: got %b expected 0", out_valid); end
      compared++;
      if (result_full !== '0 || result_dot !== '0) begin
         mismatched++;
         $display("[TB] FAIL midflight_results: got f=%h d=%h expected 0", result_full, result_dot);
      end
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midflight_in_ready: got %b expected 1", in_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      qFull.delete();
      qDot.delete();
      repeat (4) tick();
      compared++;
      if (qFull.size() != 0) begin mismatched++; $display("[TB] FAIL midflight_ghost: got %0d outputs expected 0", qFull.size()); end
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, AW'(3), AW'(4));
      tick();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, {9{9'd1}}, {9{9'd1}});
      tick();
      idle();
      tick();
      compared++;
      if (out_valid !== 1'b1 || result_full !== FULL_W'(12)) begin
         mismatched++;
         $display("[TB] FAIL post_reset_full_acc: got v=%b %0d expected v=1 12", out_valid, result_full);
      end
      tick();
      compared++;
      if (out_valid !== 1'b1 || result_dot !== {3{29'd3}}) begin
         mismatched++;
         $display("[TB] FAIL post_reset_dot_acc: got v=%b %h expected v=1 %h", out_valid, result_dot, {3{29'd3}});
      end
      tick();
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_full();
      test_dot();
      test_full_acc();
      test_mixed_modes();
      test_back_to_back();
      test_dot_acc_wrap();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
